// File: rtl/common_defs.sv
// Shared types and address constants for the memory/IO responder.
//   byte_t / word_t / addr_t : bus data and address types
//   IO_UART_ADDR             : UART data register (write = TX push, read = RX pop)
//   IO_CNT_ADDR              : cycle-counter snapshot / halt register (4 bytes)
//   rd_src_e                 : which register drives the read-data bus
//   byte_sel                 : little-endian byte extraction from a word
package common_defs;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  localparam addr_t IO_UART_ADDR = 32'h0003_0000;
  localparam addr_t IO_CNT_ADDR  = 32'h0003_0004;

  typedef enum logic {
    RD_RAM = 1'b0,
    RD_IO  = 1'b1
  } rd_src_e;

  function automatic byte_t byte_sel(input word_t w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_io_resp_if.sv
// CPU memory bus between the core and the memory/IO responder.
//   bus_a     : byte address from the CPU
//   bus_wdata : write byte from the CPU
//   bus_wr    : 1 = write, 0 = read
//   bus_rdata : read byte back to the CPU (valid the cycle after an accepted read)
//   rdy_out   : low freezes the CPU and holds the bus
interface mem_io_resp_if;
  import common_defs::*;

  addr_t bus_a;
  byte_t bus_wdata;
  logic  bus_wr;
  byte_t bus_rdata;
  logic  rdy_out;

  modport master (
    output bus_a, bus_wdata, bus_wr,
    input  bus_rdata, rdy_out
  );

  modport slave (
    input  bus_a, bus_wdata, bus_wr,
    output bus_rdata, rdy_out
  );

endinterface

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write push_data (ignored when full)
//   push_data : byte to enqueue
//   pop       : drop head (ignored when empty)
//   full      : count == TX_DEPTH
//   empty     : count == 0
//   head      : oldest byte, stable until popped
module tx_fifo
  import common_defs::*;
#(
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t push_data,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output byte_t head
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;

  byte_t         mem [TX_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(TX_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_resp.sv
// Memory and IO responder for a single-cycle CPU bus.
//   clk_in, rst_in : clock, synchronous active-high reset
//   bus            : CPU bus (address, write data, write strobe, read data, ready)
//   rx_data/valid  : UART receive byte and its valid flag
//   rx_pop         : one-cycle acknowledge consuming rx_data
//   tx_data/valid  : TX FIFO head to the UART transmitter
//   tx_ready       : transmitter accepts the head byte
//   halt           : sticky stop flag, set by writing the counter register
// Map: bus_a[17:16]==2'b11 selects IO, anything else hits the internal RAM.
module mem_io_resp
  import common_defs::*;
#(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned TX_DEPTH   = 8
) (
  input  logic  clk_in,
  input  logic  rst_in,
  mem_io_resp_if.slave bus,
  input  byte_t rx_data,
  input  logic  rx_valid,
  output logic  rx_pop,
  output byte_t tx_data,
  output logic  tx_valid,
  input  logic  tx_ready,
  output logic  halt
);

  localparam int unsigned RAM_BYTES = 1 << RAM_ADDR_W;

  byte_t                 ram [RAM_BYTES];
  byte_t                 ram_q;
  logic [RAM_ADDR_W-1:0] ram_addr;

  word_t   cycle_cnt;
  word_t   snapshot;
  byte_t   io_q;
  byte_t   io_rd_byte;
  rd_src_e rd_src;

  logic  is_io;
  logic  is_uart;
  logic  is_cnt;
  logic  push_req;
  logic  rx_wait;
  logic  stall;
  logic  accept;
  logic  fifo_push;
  logic  fifo_pop;
  logic  fifo_full;
  logic  fifo_empty;
  byte_t push_byte;
  logic  unused_addr_bits;

  assign unused_addr_bits = ^bus.bus_a[31:18];

  assign is_io    = (bus.bus_a[17:16] == 2'b11);
  assign is_uart  = is_io && (bus.bus_a[15:0] == IO_UART_ADDR[15:0]);
  assign is_cnt   = is_io && (bus.bus_a[15:2] == IO_CNT_ADDR[15:2]);
  assign ram_addr = bus.bus_a[RAM_ADDR_W-1:0];

  // Zero bytes to the UART register are dropped; counter-register writes
  // always enqueue a 0x00 terminator.
  assign push_req  = bus.bus_wr && ((is_uart && (bus.bus_wdata != '0)) || is_cnt);
  assign push_byte = is_cnt ? '0 : bus.bus_wdata;
  assign rx_wait   = is_uart && !bus.bus_wr && !rx_valid;

  // Full is the registered FIFO state, so a pop in the same cycle does not
  // release a stalled push until the following cycle.
  assign stall       = halt || (push_req && fifo_full) || rx_wait;
  assign bus.rdy_out = !stall;

  // Reset blocks acceptance so a stalled access is abandoned without effect.
  assign accept    = !stall && !rst_in;
  assign fifo_push = accept && push_req;
  assign rx_pop    = accept && is_uart && !bus.bus_wr;
  assign fifo_pop  = tx_valid && tx_ready;
  assign tx_valid  = !fifo_empty;

  tx_fifo #(
    .TX_DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (fifo_push),
    .push_data (push_byte),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (tx_data)
  );

  // Single-port RAM without reset so it maps onto block RAM.
  always_ff @(posedge clk_in) begin
    if (accept && !is_io) begin
      if (bus.bus_wr) begin
        ram[ram_addr] <= bus.bus_wdata;
      end else begin
        ram_q <= ram[ram_addr];
      end
    end
  end

  // Byte 0 of the counter comes straight from the live count (it is the
  // value captured into the snapshot on that same edge).
  always_comb begin
    io_rd_byte = '0;
    if (is_uart) begin
      io_rd_byte = rx_data;
    end else if (is_cnt) begin
      io_rd_byte = (bus.bus_a[1:0] == 2'b00) ? cycle_cnt[7:0]
                                              : byte_sel(snapshot, bus.bus_a[1:0]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cycle_cnt <= '0;
      snapshot  <= '0;
      halt      <= 1'b0;
      io_q      <= '0;
      rd_src    <= RD_IO;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (accept && !bus.bus_wr) begin
        rd_src <= is_io ? RD_IO : RD_RAM;
        if (is_io) begin
          io_q <= io_rd_byte;
        end
        if (is_cnt && (bus.bus_a[1:0] == 2'b00)) begin
          snapshot <= cycle_cnt;
        end
      end
      if (fifo_push && is_cnt) begin
        halt <= 1'b1;
      end
    end
  end

  // The read mux selects a registered source, so the byte holds until the
  // next accepted read.
  assign bus.bus_rdata = (rd_src == RD_RAM) ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_resp.sv
// Directed testbench for mem_io_resp: a vector table for plain RAM/IO
// accesses, then hand-written sequences for TX FIFO, RX wait, counter
// snapshot, halt and reset-during-stall behaviour.
module tb_mem_io_resp;

  logic       clk;
  logic       rst_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_pop;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       halt;

  mem_io_resp_if bus_if ();

  mem_io_resp #(
    .RAM_ADDR_W (17),
    .TX_DEPTH   (8)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst_in),
    .bus      (bus_if),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_pop   (rx_pop),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .halt     (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference cycle counter: cleared on a reset edge, +1 on every other edge.
  logic [31:0] mcnt;
  always @(posedge clk) mcnt <= rst_in ? 32'd0 : mcnt + 32'd1;

  // Bytes handed to the transmitter and RX acknowledge pulses.
  logic [7:0] txq[$];
  int         rxp = 0;
  always @(negedge clk) begin
    if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
    if (rx_pop) rxp++;
  end

  typedef struct {
    logic [31:0] a;
    logic [7:0]  wd;
    logic        wr;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input logic [31:0] a, input logic [7:0] wd, input logic wr);
    bus_if.bus_a     = a;
    bus_if.bus_wdata = wd;
    bus_if.bus_wr    = wr;
  endtask

  // Write to an unmapped IO address: no side effects, never stalls.
  task automatic idle();
    bus_op(32'h0003_0008, 8'h00, 1'b1);
  endtask

  task automatic chk_txq(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_count"}, txq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk(nm, (i < txq.size()) ? txq[i] : 8'hxx, exp[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] snap_exp;
    logic [7:0]  exp_q[$];

    vt[0] = '{32'h0000_0010, 8'hA5, 1'b1, 1'b0, 8'h00};
    vt[1] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'hA5};
    vt[2] = '{32'h0001_FFFF, 8'h3C, 1'b1, 1'b0, 8'h00};
    vt[3] = '{32'h0000_0000, 8'hC3, 1'b1, 1'b0, 8'h00};
    vt[4] = '{32'h0001_FFFF, 8'h00, 1'b0, 1'b1, 8'h3C};
    vt[5] = '{32'h0000_0000, 8'h00, 1'b0, 1'b1, 8'hC3};
    vt[6] = '{32'h0003_0008, 8'h00, 1'b0, 1'b1, 8'h00};
    vt[7] = '{32'h0003_000C, 8'h77, 1'b1, 1'b0, 8'h00};
    vt[8] = '{32'h0000_0010, 8'h00, 1'b0, 1'b1, 8'hA5};

    rst_in   = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    idle();
    step();
    step();
    rst_in = 1'b0;

    chk("rst_rdata", bus_if.bus_rdata, 8'h00);
    chk("rst_rdy", bus_if.rdy_out, 1'b1);
    chk("rst_rx_pop", rx_pop, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_halt", halt, 1'b0);

    // Table: RAM/IO accesses that never stall
    for (int i = 0; i < 9; i++) begin
      bus_op(vt[i].a, vt[i].wd, vt[i].wr);
      @(negedge clk);
      chk("tbl_rdy", bus_if.rdy_out, 1'b1);
      step();
      if (vt[i].chk) chk("tbl_rdata", bus_if.bus_rdata, vt[i].exp);
    end
    idle();
    chk("tbl_no_push", tx_valid, 1'b0);

    // 'H', 0x00, 'i' -> only 'H','i' transmitted
    tx_ready = 1'b1;
    txq.delete();
    bus_op(32'h0003_0000, 8'h48, 1'b1); step();
    bus_op(32'h0003_0000, 8'h00, 1'b1); step();
    bus_op(32'h0003_0000, 8'h69, 1'b1); step();
    idle();
    repeat (5) step();
    exp_q = '{8'h48, 8'h69};
    chk_txq("tx_hi", exp_q);

    // Fill FIFO with tx_ready low; 9th write stalls until a pop
    tx_ready = 1'b0;
    txq.delete();
    for (int i = 1; i <= 8; i++) begin
      bus_op(32'h0003_0000, 8'(i), 1'b1);
      @(negedge clk);
      chk("fill_rdy", bus_if.rdy_out, 1'b1);
      step();
    end
    bus_op(32'h0003_0000, 8'h09, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_stall", bus_if.rdy_out, 1'b0);
      chk("full_head", tx_data, 8'h01);
      step();
    end
    tx_ready = 1'b1;
    @(negedge clk);
    chk("full_pop_cycle", bus_if.rdy_out, 1'b0);
    step();
    @(negedge clk);
    chk("full_release", bus_if.rdy_out, 1'b1);
    step();
    idle();
    repeat (12) step();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    chk_txq("full_seq", exp_q);

    // UART read waits for rx_valid
    rxp = 0;
    bus_op(32'h0003_0000, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rx_wait_rdy", bus_if.rdy_out, 1'b0);
      chk("rx_wait_pop", rx_pop, 1'b0);
      step();
    end
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("rx_go_rdy", bus_if.rdy_out, 1'b1);
    chk("rx_go_pop", rx_pop, 1'b1);
    step();
    rx_valid = 1'b0;
    idle();
    chk("rx_rdata", bus_if.bus_rdata, 8'h41);
    step();
    step();
    chk("rx_rdata_hold", bus_if.bus_rdata, 8'h41);
    chk("rx_pulses", rxp, 1);

    // Counter snapshot taken at cnt=0x1FF
    for (int g = 0; g < 2000 && mcnt != 32'h0000_01FF; g++) step();
    chk("cnt_reach", mcnt, 32'h0000_01FF);
    bus_op(32'h0003_0004, 8'h00, 1'b0); step();
    chk("snap_b0", bus_if.bus_rdata, 8'hFF);
    bus_op(32'h0003_0005, 8'h00, 1'b0); step();
    chk("snap_b1", bus_if.bus_rdata, 8'h01);
    bus_op(32'h0003_0006, 8'h00, 1'b0); step();
    chk("snap_b2", bus_if.bus_rdata, 8'h00);
    bus_op(32'h0003_0007, 8'h00, 1'b0); step();
    chk("snap_b3", bus_if.bus_rdata, 8'h00);
    idle();
    repeat (3) step();
    snap_exp = mcnt;
    bus_op(32'h0003_0004, 8'h00, 1'b0); step();
    chk("snap2_b0", bus_if.bus_rdata, snap_exp[7:0]);
    idle();
    step();
    bus_op(32'h0003_0005, 8'h00, 1'b0); step();
    chk("snap2_b1", bus_if.bus_rdata, snap_exp[15:8]);
    idle();

    // Halt: 0x00 emitted, CPU frozen until reset
    tx_ready = 1'b1;
    txq.delete();
    bus_op(32'h0003_0004, 8'h55, 1'b1);
    @(negedge clk);
    chk("halt_wr_rdy", bus_if.rdy_out, 1'b1);
    step();
    idle();
    @(negedge clk);
    chk("halt_set", halt, 1'b1);
    chk("halt_rdy", bus_if.rdy_out, 1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("halt_rdy_stays", bus_if.rdy_out, 1'b0);
    exp_q = '{8'h00};
    chk_txq("halt_tx", exp_q);
    step();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("halt_clr", halt, 1'b0);
    chk("halt_clr_rdy", bus_if.rdy_out, 1'b1);
    chk("halt_clr_rdata", bus_if.bus_rdata, 8'h00);

    // Reset while a UART read is stalled: no pop, read abandoned
    step();
    rxp = 0;
    bus_op(32'h0003_0000, 8'h00, 1'b0);
    @(negedge clk);
    chk("rst_stall_rdy", bus_if.rdy_out, 1'b0);
    step();
    rst_in   = 1'b1;
    rx_data  = 8'h99;
    rx_valid = 1'b1;
    @(negedge clk);
    chk("rst_stall_pop", rx_pop, 1'b0);
    step();
    rst_in   = 1'b0;
    rx_valid = 1'b0;
    idle();
    @(negedge clk);
    chk("rst_stall_rdata", bus_if.bus_rdata, 8'h00);
    chk("rst_stall_pulses", rxp, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
